// File: rtl/ccc_lock_reset_seq.sv
// ccc_lock_reset_seq: waits for stable CCC lock, releases core then periph reset, logs lock loss.
// Define LOCK_LOSS_CNT_EN to keep the saturating LOSS_COUNT register; otherwise LOSS_COUNT is tied to zero.
module ccc_lock_reset_seq #(
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned STAGE_GAP     = 8,
    parameter int unsigned HOLD_CYCLES   = 16
) (
    input  logic       FAB_CLK,
    input  logic       M2F_RESET_N,
    input  logic       FAB_LOCK,
    input  logic       MSS_LOCK,
    input  logic       CLR_LOST,
    output logic       CORE_RESET_N,
    output logic       PERIPH_RESET_N,
    output logic       READY,
    output logic       LOCK_LOST,
    output logic [7:0] LOSS_COUNT,
    output logic [2:0] STATE
);
    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABILIZE = 3'd1,
        RELEASE   = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_t;

    localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);
    localparam logic [15:0] GAP_LAST    = 16'(STAGE_GAP - 1);
    localparam logic [15:0] HOLD_LAST   = 16'(HOLD_CYCLES - 1);

    state_t      state, nxt;
    logic [1:0]  sync;
    logic [15:0] cnt;
    logic        lock_s, loss;

    assign lock_s = sync[1];
    assign loss   = !lock_s && (state == RELEASE || state == RUN);
    assign STATE  = state;

    always_comb begin
        nxt = FAULT;
        case (state)
            WAIT_LOCK: nxt = lock_s ? STABILIZE : WAIT_LOCK;
            STABILIZE: nxt = !lock_s ? WAIT_LOCK : (cnt == STABLE_LAST) ? RELEASE : STABILIZE;
            RELEASE:   nxt = !lock_s ? FAULT : (cnt == GAP_LAST) ? RUN : RELEASE;
            RUN:       nxt = lock_s ? RUN : FAULT;
            FAULT:     nxt = (cnt == HOLD_LAST) ? WAIT_LOCK : FAULT;
            default:   nxt = FAULT;
        endcase
    end

    // Outputs decode the next state so they are registered alongside it.
    always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
        if (!M2F_RESET_N) begin
            sync           <= '0;
            state          <= WAIT_LOCK;
            cnt            <= '0;
            CORE_RESET_N   <= 1'b0;
            PERIPH_RESET_N <= 1'b0;
            READY          <= 1'b0;
            LOCK_LOST      <= 1'b0;
        end else begin
            sync           <= {sync[0], FAB_LOCK & MSS_LOCK};
            state          <= nxt;
            cnt            <= (nxt == state) ? cnt + 16'd1 : '0;
            CORE_RESET_N   <= nxt == RELEASE || nxt == RUN;
            PERIPH_RESET_N <= nxt == RUN;
            READY          <= nxt == RUN;
            LOCK_LOST      <= loss | (LOCK_LOST & !CLR_LOST);
        end
    end

`ifdef LOCK_LOSS_CNT_EN
    always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
        if (!M2F_RESET_N)
            LOSS_COUNT <= '0;
        else if (loss && LOSS_COUNT != 8'hff)
            LOSS_COUNT <= LOSS_COUNT + 8'd1;
    end
`else
    assign LOSS_COUNT = 8'd0;
`endif
endmodule

// File: tb/tb_ccc_lock_reset_seq.sv
// tb_ccc_lock_reset_seq: scoreboard bench; expected output vectors are queued per clock edge as stimulus is driven.
module tb_ccc_lock_reset_seq;
    localparam int S = 128;
    localparam int G = 8;
    localparam int H = 16;

    logic       FAB_CLK = 0, M2F_RESET_N = 1, FAB_LOCK = 1, MSS_LOCK = 1, CLR_LOST = 0;
    logic       CORE_RESET_N, PERIPH_RESET_N, READY, LOCK_LOST;
    logic [7:0] LOSS_COUNT;
    logic [2:0] STATE;
    logic [14:0] obs;

    typedef struct {
        int          cyc;
        string       tag;
        logic [14:0] v;
    } exp_t;

    exp_t       q[$];
    int         cyc = 0, n_cmp = 0, n_bad = 0, rise_cyc = 0;
    logic       lost_m = 0;
    logic [7:0] cnt_m = 0;

    ccc_lock_reset_seq #(.STABLE_CYCLES(S), .STAGE_GAP(G), .HOLD_CYCLES(H)) dut (
        .FAB_CLK(FAB_CLK), .M2F_RESET_N(M2F_RESET_N), .FAB_LOCK(FAB_LOCK), .MSS_LOCK(MSS_LOCK),
        .CLR_LOST(CLR_LOST), .CORE_RESET_N(CORE_RESET_N), .PERIPH_RESET_N(PERIPH_RESET_N),
        .READY(READY), .LOCK_LOST(LOCK_LOST), .LOSS_COUNT(LOSS_COUNT), .STATE(STATE)
    );

    assign obs = {CORE_RESET_N, PERIPH_RESET_N, READY, LOCK_LOST, LOSS_COUNT, STATE};

    always #5 FAB_CLK = ~FAB_CLK;
    always @(posedge FAB_CLK) cyc <= cyc + 1;

    function automatic logic [14:0] vec(input logic core, input logic per, input logic rdy, input logic [2:0] st);
        return {core, per, rdy, lost_m, cnt_m, st};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_cmp++;
        if (got !== exp_v) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp_v);
        end
    endtask

    task automatic push(input int c, input string tag, input logic [14:0] v);
        exp_t e;
        int i = 0;
        e.cyc = c;
        e.tag = tag;
        e.v   = v;
        while (i < q.size() && q[i].cyc <= c) i++;
        q.insert(i, e);
    endtask

    always @(negedge FAB_CLK)
        while (q.size() != 0 && q[0].cyc <= cyc) begin
            check(q[0].tag, 32'(obs), 32'(q[0].v));
            void'(q.pop_front());
        end

    // b is the edge at which STABILIZE is entered.
    task automatic push_seq(input int b);
        push(b, "stab_entry", vec(0, 0, 0, 3'd1));
        push(b + S - 1, "stab_last", vec(0, 0, 0, 3'd1));
        push(b + S, "core_rise", vec(1, 0, 0, 3'd2));
        push(b + S + G - 1, "periph_hold", vec(1, 0, 0, 3'd2));
        push(b + S + G, "run", vec(1, 1, 1, 3'd3));
        rise_cyc = b + S;
    endtask

    task automatic drain();
        int k = 0;
        while (q.size() != 0 && k < 1000) begin
            @(negedge FAB_CLK);
            k++;
        end
        check("drain", 32'(q.size()), 32'd0);
        q.delete();
    endtask

    // One-cycle MSS_LOCK drop from RUN; optionally CLR_LOST lands in the loss-detect cycle.
    task automatic lose(input logic clr_too);
        int f = cyc + 3;
        push(f - 1, "pre_loss", vec(1, 1, 1, 3'd3));
        lost_m = 1;
`ifdef LOCK_LOSS_CNT_EN
        if (cnt_m != 8'hff) cnt_m = cnt_m + 8'd1;
`endif
        push(f, "fault_entry", vec(0, 0, 0, 3'd4));
        push(f + H - 1, "fault_last", vec(0, 0, 0, 3'd4));
        push(f + H, "fault_exit", vec(0, 0, 0, 3'd0));
        push_seq(f + H + 1);
        MSS_LOCK = 0;
        @(negedge FAB_CLK) MSS_LOCK = 1;
        @(negedge FAB_CLK) CLR_LOST = clr_too;
        @(negedge FAB_CLK) CLR_LOST = 0;
    endtask

    task automatic clear();
        CLR_LOST = 1;
        lost_m = 0;
        push(cyc + 1, "clr", vec(1, 1, 1, 3'd3));
        push(cyc + 2, "clr_hold", vec(1, 1, 1, 3'd3));
        @(negedge FAB_CLK) CLR_LOST = 0;
    endtask

    initial begin
        int b, g;
        #2 M2F_RESET_N = 0;
        #1 check("por_async", 32'(obs), 32'd0);
        repeat (5) @(negedge FAB_CLK);
        M2F_RESET_N = 1;
        push(cyc + 2, "edge1_wait", vec(0, 0, 0, 3'd0));
        push_seq(cyc + 3);
        drain();
        lose(0);
        drain();
        clear();
        drain();
        lose(1);
        drain();
        clear();
        drain();
        repeat (258) begin
            lose(0);
            drain();
        end
        lose(0);
        while (cyc < rise_cyc + 3) @(negedge FAB_CLK);
        #2;
        check("pre_rst_release", 32'(obs), 32'(vec(1, 0, 0, 3'd2)));
        q.delete();
        M2F_RESET_N = 0;
        lost_m = 0;
        cnt_m = 0;
        #1 check("mid_release_rst", 32'(obs), 32'd0);
        repeat (3) @(negedge FAB_CLK);
        M2F_RESET_N = 1;
        b = cyc + 3;
        push(b, "stab_entry_g", vec(0, 0, 0, 3'd1));
        while (cyc < b + S / 2) @(negedge FAB_CLK);
        g = cyc;
        FAB_LOCK = 0;
        push(g + 2, "glitch_stab", vec(0, 0, 0, 3'd1));
        push(g + 3, "glitch_wait", vec(0, 0, 0, 3'd0));
        push(g + 5, "glitch_wait_end", vec(0, 0, 0, 3'd0));
        push_seq(g + 6);
        repeat (3) @(negedge FAB_CLK);
        FAB_LOCK = 1;
        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
